// File: rtl/team_09_gpio_arbiter_pkg.sv
// Shared types and defaults for the GPIO bank arbiter: FSM state encoding,
// default bank geometry and the grant-counter width.
package team_09_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 34;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/team_09_gpio_arbiter_rr_picker.sv
// Round-robin winner selection: scan starts one past the previous owner and
// wraps, so a requester that just held the bank yields to any other requester.
module team_09_rr_picker
    import team_09_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int OW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last_owner,
    output logic            valid,
    output logic [NREQ-1:0] pick
);

    logic [OW-1:0] idx;

    always_comb begin
        valid = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(last_owner) + k) % NREQ);
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/team_09_gpio_arbiter.sv
// Shares one GPIO pad bank between NREQ requesters; the grantee's drive and
// enable slices are registered onto the pads, with a one-cycle turnaround.
module team_09_gpio_arbiter
    import team_09_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int TIMEOUT = 255,
    localparam int OW      = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       done,
    input  logic [NREQ*WIDTH-1:0] req_out,
    input  logic [NREQ*WIDTH-1:0] req_oeb,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  timeout,
    output logic [WIDTH-1:0]      gpio_out,
    output logic [WIDTH-1:0]      gpio_oeb
);

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);

    state_t                       state;
    logic   [CNT_W-1:0]           cnt;
    logic   [OW-1:0]              last_owner;
    logic                         pick_vld;
    logic   [NREQ-1:0]            pick;
    logic   [OW-1:0]              pick_idx;
    logic   [NREQ-1:0][WIDTH-1:0] out_v;
    logic   [NREQ-1:0][WIDTH-1:0] oeb_v;
    logic                         rel_req;

    assign out_v = req_out;
    assign oeb_v = req_oeb;

    team_09_rr_picker #(.NREQ(NREQ)) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_vld),
        .pick       (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) pick_idx = OW'(i);
    end

    // Only the owner's strobes matter; everyone else is ignored while granted.
    assign rel_req = done[owner] || !req[owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            gpio_out   <= '0;
            gpio_oeb   <= '1;
            cnt        <= '0;
            last_owner <= OW'(NREQ - 1);
        end else if (!en) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            gpio_out <= '0;
            gpio_oeb <= '1;
            cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    gpio_out <= '0;
                    gpio_oeb <= '1;
                    cnt      <= '0;
                    if (pick_vld) begin
                        state      <= GRANT;
                        gnt        <= pick;
                        owner      <= pick_idx;
                        last_owner <= pick_idx;
                        busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    // A release strobe on the expiry cycle wins over the timeout.
                    if (rel_req || cnt == TMAX) begin
                        state    <= RELEASE;
                        gnt      <= '0;
                        owner    <= '0;
                        gpio_out <= '0;
                        gpio_oeb <= '1;
                        cnt      <= '0;
                        timeout  <= !rel_req;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        gpio_out <= out_v[owner];
                        gpio_oeb <= oeb_v[owner];
                    end
                end
                RELEASE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    gpio_out <= '0;
                    gpio_oeb <= '1;
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    owner    <= '0;
                    busy     <= 1'b0;
                    gpio_out <= '0;
                    gpio_oeb <= '1;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule
